// File: rtl/string_streamer.sv
// Streams a latched packed ASCII string one character per valid/ready beat, stopping at the first null.
// Optional STRING_STREAMER_REPEAT_EN adds input repeat_en: loop the same string while it is high at the last beat.
module string_streamer #(
   parameter int MAX_CHARS  = 8,
   parameter int GAP_CYCLES = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic [8*MAX_CHARS-1:0]       value,
`ifdef STRING_STREAMER_REPEAT_EN
   input  logic                         repeat_en,
`endif
   output logic [7:0]                   char_data,
   output logic                         char_valid,
   input  logic                         char_ready,
   output logic                         char_last,
   output logic [$clog2(MAX_CHARS):0]   char_index,
   output logic                         busy,
   output logic                         done
);

   // state  | meaning
   // IDLE   | waiting for start
   // SEND   | char_valid high, presenting shadow[idx]
   // GAP    | idle spacing between characters
   // DONE   | one-cycle done pulse
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   localparam int IDX_W   = $clog2(MAX_CHARS) + 1;
   localparam bit HAS_GAP = (GAP_CYCLES > 0);
   localparam int GAP_W   = HAS_GAP ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

   state_t                 state, state_next;
   logic [8*MAX_CHARS-1:0] shadow;
   logic [IDX_W-1:0]       idx;
   logic [GAP_W-1:0]       gap_cnt;
   logic                   loop_q;
   logic                   rep_in;
   logic [7:0]             cur_char;
   logic [7:0]             nxt_char;
   logic                   is_last;

`ifdef STRING_STREAMER_REPEAT_EN
   assign rep_in = repeat_en;
`else
   assign rep_in = 1'b0;
`endif

   always_comb begin
      cur_char = 8'h00;
      nxt_char = 8'h00;
      for (int i = 0; i < MAX_CHARS; i++) begin
         if (idx == IDX_W'(i)) cur_char = shadow[8*i +: 8];
      end
      for (int i = 0; i < MAX_CHARS - 1; i++) begin
         if (idx == IDX_W'(i)) nxt_char = shadow[8*(i+1) +: 8];
      end
      is_last = (idx == IDX_W'(MAX_CHARS - 1)) || (nxt_char == 8'h00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start) state_next = (value[7:0] == 8'h00) ? S_DONE : S_SEND;
            S_SEND: if (char_ready) state_next = is_last ? S_DONE : (HAS_GAP ? S_GAP : S_SEND);
            S_GAP:  if (gap_cnt == '0) state_next = S_SEND;
            S_DONE: state_next = loop_q ? (HAS_GAP ? S_GAP : S_SEND) : S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Shadow string, character index and gap down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow  <= '0;
         idx     <= '0;
         gap_cnt <= '0;
         loop_q  <= 1'b0;
      end else if (abort) begin
         idx    <= '0;
         loop_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  shadow <= value;
                  idx    <= '0;
                  loop_q <= 1'b0;
               end
            end
            S_SEND: begin
               if (char_ready) begin
                  gap_cnt <= GAP_LOAD;
                  if (is_last) loop_q <= rep_in;
                  else         idx    <= idx + IDX_W'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
            end
            S_DONE: begin
               if (loop_q) begin
                  idx     <= '0;
                  gap_cnt <= GAP_LOAD;
               end
               loop_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      char_valid = (state == S_SEND);
      char_data  = char_valid ? cur_char : 8'h00;
      char_last  = char_valid & is_last;
      char_index = char_valid ? idx : '0;
      busy       = (state != S_IDLE);
      done       = (state == S_DONE);
   end

endmodule

// File: tb/tb_string_streamer.sv
// Randomized bench for string_streamer: two instances (no gap, 3-cycle gap) checked against a character-queue scoreboard.
module tb_string_streamer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        char_ready = 1'b0;
   logic [63:0] value = '0;
`ifdef STRING_STREAMER_REPEAT_EN
   logic        repeat_en = 1'b0;
`endif

   logic [7:0] cd0, cd3;
   logic       cv0, cv3, cl0, cl3, bz0, bz3, dn0, dn3;
   logic [3:0] ci0, ci3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   string_streamer #(.MAX_CHARS(8), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .value(value),
`ifdef STRING_STREAMER_REPEAT_EN
      .repeat_en(repeat_en),
`endif
      .char_data(cd0), .char_valid(cv0), .char_ready(char_ready), .char_last(cl0),
      .char_index(ci0), .busy(bz0), .done(dn0));

   string_streamer #(.MAX_CHARS(8), .GAP_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .value(value),
`ifdef STRING_STREAMER_REPEAT_EN
      .repeat_en(repeat_en),
`endif
      .char_data(cd3), .char_valid(cv3), .char_ready(char_ready), .char_last(cl3),
      .char_index(ci3), .busy(bz3), .done(dn3));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // mode 0: ready always high, 1: ready toggles, 2: ready random
   task automatic run_stream(input logic [63:0] v, input int mode);
      logic [7:0] expq[$];
      int         n, t;
      int         pos[2], gapn[2];
      int         gap_exp[2];
      bit         fin[2], want_done[2], idle_chk[2], hold[2], gap_pend[2];
      logic [7:0] hold_d[2];
      logic [7:0] o_cd;
      logic [3:0] o_ci;
      logic       o_cv, o_cl, o_bz, o_dn;
      gap_exp[0] = 0;
      gap_exp[1] = 3;
      for (int i = 0; i < 8; i++) begin
         if (v[8*i +: 8] == 8'h00) break;
         expq.push_back(v[8*i +: 8]);
      end
      n = expq.size();
      for (int d = 0; d < 2; d++) begin
         pos[d] = 0; gapn[d] = 0; fin[d] = 0; want_done[d] = 0;
         idle_chk[d] = 0; hold[d] = 0; gap_pend[d] = 0; hold_d[d] = 8'h00;
      end
      @(negedge clk);
      value = v;
      start = 1'b1;
      char_ready = 1'b1;
      t = 0;
      while (!(fin[0] && fin[1]) && t < 200) begin
         @(negedge clk);
         t++;
         start = 1'b0;
         if (t == 3 && bz0 && bz3) start = 1'b1;
         value = {$urandom, $urandom};
         case (mode)
            0:       char_ready = 1'b1;
            1:       char_ready = t[0];
            default: char_ready = 1'($urandom_range(0, 1));
         endcase
         for (int d = 0; d < 2; d++) begin
            if (d == 0) begin o_cd = cd0; o_ci = ci0; o_cv = cv0; o_cl = cl0; o_bz = bz0; o_dn = dn0; end
            else        begin o_cd = cd3; o_ci = ci3; o_cv = cv3; o_cl = cl3; o_bz = bz3; o_dn = dn3; end
            if (fin[d]) continue;
            if (t == 1) begin
               check_eq($sformatf("d%0d_first_valid", d), o_cv, n > 0);
               check_eq($sformatf("d%0d_first_done", d), o_dn, n == 0);
               check_eq($sformatf("d%0d_first_busy", d), o_bz, 1);
            end
            if (idle_chk[d]) begin
               check_eq($sformatf("d%0d_idle_after_done", d), {o_bz, o_cv, o_dn}, 0);
               fin[d] = 1;
            end else if (want_done[d]) begin
               check_eq($sformatf("d%0d_done_pulse", d), {o_dn, o_bz, o_cv}, 3'b110);
               idle_chk[d] = 1;
            end else if (n == 0) begin
               idle_chk[d] = 1;
            end else begin
               check_eq($sformatf("d%0d_done_low", d), o_dn, 0);
               if (hold[d]) check_eq($sformatf("d%0d_hold", d), {o_cv, o_cd}, {1'b1, hold_d[d]});
               hold[d] = 0;
               if (o_cv) begin
                  if (gap_pend[d]) check_eq($sformatf("d%0d_gap_len", d), gapn[d], gap_exp[d]);
                  gap_pend[d] = 0;
                  check_eq($sformatf("d%0d_in_range", d), pos[d] < n, 1);
                  if (pos[d] < n) begin
                     check_eq($sformatf("d%0d_data", d), o_cd, expq[pos[d]]);
                     check_eq($sformatf("d%0d_index", d), o_ci, pos[d]);
                     check_eq($sformatf("d%0d_last", d), o_cl, pos[d] == n - 1);
                  end
                  if (char_ready) begin
                     if (pos[d] == n - 1) want_done[d] = 1;
                     else begin gap_pend[d] = 1; gapn[d] = 0; end
                     pos[d]++;
                  end else begin
                     hold[d] = 1;
                     hold_d[d] = o_cd;
                  end
               end else begin
                  gapn[d]++;
               end
            end
         end
      end
      check_eq("stream_complete", fin[0] && fin[1], 1);
      start = 1'b0;
      char_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] rv;
      int          k;
      #1;
      check_eq("reset_outputs", {cd0, cv0, cl0, ci0, bz0, dn0, cd3, cv3, bz3, dn3}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_stream(64'h0000_0000_0000_4948, 0);   // "HI"
      run_stream(64'h0, 0);                     // empty
      run_stream(64'h4847_4645_4443_4241, 1);   // "ABCDEFGH"
      run_stream(64'h0000_0000_005A_3041, 2);   // "A0Z"
      run_stream(64'h5A00_0000_0000_0041, 0);   // "A" then junk after null

      // abort during the second character of "XYZ"
      @(negedge clk);
      value = 64'h5A5958;
      start = 1'b1;
      char_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (k = 0; k < 10 && !(cv0 && ci0 == 4'd1); k++) @(negedge clk);
      check_eq("abort_reached_idx1", cv0 && ci0 == 4'd1, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq("abort_idle", {cv0, dn0, bz0, cv3, dn3, bz3}, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("abort_no_done", {dn0, dn3, bz0, bz3}, 0);
      end

      // start together with abort in IDLE is ignored
      value = 64'h4948;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_eq("abort_start_idle", {bz0, cv0, bz3}, 0);

      for (int i = 0; i < 20; i++) begin
         rv = {$urandom, $urandom};
         k = $urandom_range(0, 9);
         if (k < 8) rv[8*k +: 8] = 8'h00;
         run_stream(rv, $urandom_range(0, 2));
      end

      // asynchronous reset in the middle of SEND
      value = 64'h4847_4645_4443_4241;
      start = 1'b1;
      char_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_eq("pre_reset_valid", cv0, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_reset", {cd0, cv0, cl0, ci0, bz0, dn0, cd3, cv3, bz3, dn3}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_reset_idle", {bz0, bz3}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
